// File: rtl/rr_stream_mux.sv
// rr_stream_mux: packet-locking N:1 stream mux sitting behind rr_arbiter.
// Define RR_STREAM_MUX_SKID_EN for a 2-entry skid output stage.
module rr_stream_mux #(
  parameter int NUM_PORTS  = 6,
  parameter int SEL_WIDTH  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_PORTS-1:0]            s_valid,
  input  logic [NUM_PORTS-1:0]            s_last,
  output logic [NUM_PORTS-1:0]            s_ready,
  output logic [NUM_PORTS-1:0]            arb_request,
  input  logic [NUM_PORTS-1:0]            arb_grant,
  input  logic [SEL_WIDTH-1:0]            arb_select,
  input  logic                            arb_active,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            busy,
  output logic [SEL_WIDTH-1:0]            owner
);

  typedef enum logic [1:0] {
    IDLE,
    LOCK,
    RELEASE
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SEL_WIDTH-1:0]   owner_nxt;
  logic [NUM_PORTS-1:0]   owner_hot;
  logic [DATA_WIDTH-1:0]  own_data;
  logic                   own_last;
  logic                   own_valid;
  logic                   sel_valid;
  logic                   in_ready;
  logic                   accept;

  always_comb begin
    owner_hot = '0;
    own_data  = '0;
    own_last  = 1'b0;
    own_valid = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (owner == SEL_WIDTH'(i)) begin
        owner_hot[i] = 1'b1;
        own_data     = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        own_last     = s_last[i];
        own_valid    = s_valid[i];
      end
      if (arb_select == SEL_WIDTH'(i)) begin
        sel_valid = s_valid[i];
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    arb_request = '0;
    s_ready     = '0;
    accept      = 1'b0;
    unique case (state)
      IDLE: begin
        arb_request = s_valid;
        if (arb_active && sel_valid) begin
          owner_nxt = arb_select;
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        // Pin the arbiter token on the owner for the whole packet
        arb_request = owner_hot;
        s_ready     = owner_hot & {NUM_PORTS{in_ready}};
        accept      = own_valid & in_ready;
        if (accept && own_last) begin
          state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Hide the old owner for a cycle so the token moves on
        arb_request = s_valid & ~owner_hot;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      arb_request = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
    end
  end

  assign busy = (state != IDLE);

`ifdef RR_STREAM_MUX_SKID_EN
  logic [DATA_WIDTH-1:0] sk_data;
  logic                  sk_last;
  logic                  sk_valid;

  assign in_ready = ~sk_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data   <= '0;
      m_last   <= 1'b0;
      m_valid  <= 1'b0;
      sk_data  <= '0;
      sk_last  <= 1'b0;
      sk_valid <= 1'b0;
    end else if (accept) begin
      if (!m_valid || m_ready) begin
        m_data  <= own_data;
        m_last  <= own_last;
        m_valid <= 1'b1;
      end else begin
        sk_data  <= own_data;
        sk_last  <= own_last;
        sk_valid <= 1'b1;
      end
    end else if (m_ready) begin
      if (sk_valid) begin
        m_data   <= sk_data;
        m_last   <= sk_last;
        sk_valid <= 1'b0;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end
`else
  assign in_ready = ~m_valid | m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_last  <= 1'b0;
      m_valid <= 1'b0;
    end else if (accept) begin
      m_data  <= own_data;
      m_last  <= own_last;
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end
`endif

`ifndef SYNTHESIS
  grant_onehot: assert property (
    @(posedge clk) disable iff (rst)
    arb_active |-> $onehot(arb_grant)
  );
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: randomized and directed checks of rr_stream_mux
// against a round-robin packet-level reference model.
module tb_rr_stream_mux;
  localparam int N  = 6;
  localparam int SW = 3;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*DW-1:0] s_data;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_last;
  logic [N-1:0]  s_ready;
  logic [N-1:0]  arb_request;
  logic [N-1:0]  arb_grant;
  logic [SW-1:0] arb_select;
  logic          arb_active;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic          busy;
  logic [SW-1:0] owner;

  rr_stream_mux #(.NUM_PORTS(N), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .arb_request(arb_request),
    .arb_grant(arb_grant), .arb_select(arb_select),
    .arb_active(arb_active),
    .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Behavioural round-robin arbiter with registered outputs
  int tok;
  int pick;

  function automatic int rr_pick(logic [N-1:0] req, int t);
    for (int k = 0; k < N; k++) begin
      if (req[(t + k) % N]) return (t + k) % N;
    end
    return -1;
  endfunction

  always_comb pick = rr_pick(arb_request, tok);

  always @(posedge clk) begin
    if (rst) begin
      arb_grant  <= '0;
      arb_select <= '0;
      arb_active <= 1'b0;
      tok        <= 0;
    end else if (pick >= 0) begin
      arb_grant  <= N'(1) << pick;
      arb_select <= SW'(pick);
      arb_active <= 1'b1;
      tok        <= pick;
    end else begin
      arb_grant  <= '0;
      arb_active <= 1'b0;
    end
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    int            gap;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } obeat_t;

  beat_t  src_q [N][$];
  obeat_t mdl_q [N][$];
  obeat_t out_q [$];
  obeat_t exp_q [$];
  int     ord_q [$];
  int     gapcnt [N];
  bit     started [N];
  int     gap_pct;
  int     mr_mode;
  int     bp;
  int     n_checks = 0;
  int     n_err    = 0;

  // Source drivers and output monitor
  initial begin : drv
    logic [N-1:0] hs;
    forever begin
      @(negedge clk);
      hs = s_valid & s_ready;
      if (m_valid && m_ready && !rst) out_q.push_back({m_data, m_last});
      @(posedge clk);
      #1;
      if (mr_mode == 0) m_ready = 1'b1;
      else if (mr_mode == 1) m_ready = ($urandom_range(99) < 70);
      else begin
        m_ready = (bp % 4 == 0) || (bp % 4 == 3);
        bp++;
      end
      for (int p = 0; p < N; p++) begin
        if (hs[p] && src_q[p].size() > 0) begin
          src_q[p].delete(0);
          s_valid[p] = 1'b0;
          started[p] = 1'b0;
        end
        if (!s_valid[p] && src_q[p].size() > 0) begin
          if (!started[p]) begin
            gapcnt[p]  = src_q[p][0].gap;
            started[p] = 1'b1;
          end
          if (gapcnt[p] > 0) gapcnt[p]--;
          else if ($urandom_range(99) >= gap_pct) begin
            s_valid[p] = 1'b1;
            s_data[p*DW +: DW] = src_q[p][0].data;
            s_last[p] = src_q[p][0].last;
          end
        end
      end
    end
  end

  task automatic send_pkt(input int p, input int len,
                          input logic [DW-1:0] base,
                          input int gap_at, input int gap_len);
    for (int b = 0; b < len; b++) begin
      beat_t e;
      e.data = base + DW'(b);
      e.last = (b == len - 1);
      e.gap  = (b == gap_at) ? gap_len : 0;
      src_q[p].push_back(e);
      mdl_q[p].push_back({e.data, e.last});
    end
  endtask

  // Reference order: all queued packets served round-robin from token t0
  task automatic build_exp(input int t0);
    int cnt [N];
    int start;
    int found;
    obeat_t b;
    exp_q.delete();
    ord_q.delete();
    for (int p = 0; p < N; p++) begin
      cnt[p] = 0;
      foreach (mdl_q[p][i]) if (mdl_q[p][i].last) cnt[p]++;
    end
    start = t0;
    forever begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        if (found < 0 && cnt[(start + k) % N] > 0) found = (start + k) % N;
      end
      if (found < 0) break;
      ord_q.push_back(found);
      cnt[found]--;
      forever begin
        b = mdl_q[found].pop_front();
        exp_q.push_back(b);
        if (b.last) break;
      end
      start = found + 1;
    end
  endtask

  function automatic bit all_sent();
    for (int p = 0; p < N; p++) if (src_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      mdl_q[p].delete();
      started[p] = 1'b0;
      gapcnt[p]  = 0;
    end
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    mr_mode = 0;
    gap_pct = 0;
    bp      = 0;
    repeat (2) @(negedge clk);
    #2;
    out_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    s_valid = '1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (arb_request !== '0) begin
      n_err++; $display("FAIL rst_arb_request got %b exp 0", arb_request);
    end
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_m_valid got %b exp 0", m_valid);
    end
    n_checks++;
    if (m_data !== '0 || m_last !== 1'b0) begin
      n_err++; $display("FAIL rst_m_data got %h/%b exp 0/0", m_data, m_last);
    end
    n_checks++;
    if (s_ready !== '0) begin
      n_err++; $display("FAIL rst_s_ready got %b exp 0", s_ready);
    end
    n_checks++;
    if (busy !== 1'b0 || owner !== '0) begin
      n_err++; $display("FAIL rst_busy_owner got %b/%0d exp 0/0", busy, owner);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    #2;
    send_pkt(2, 3, 32'hA0, -1, 0);
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 2) begin
        n_checks++;
        if (s_ready !== 6'b000100 || owner !== 3'd2) begin
          n_err++;
          $display("FAIL single_lock got s_ready=%b owner=%0d exp 000100/2", s_ready, owner);
        end
      end
      if (c >= 3 && c <= 5) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 32'hA0 + DW'(c - 3) || m_last !== (c == 5)) begin
          n_err++;
          $display("FAIL single_beat c%0d got %b/%h/%b exp 1/%h/%b",
                   c, m_valid, m_data, m_last, 32'hA0 + DW'(c - 3), c == 5);
        end
      end
      if (c == 5 && busy !== 1'b1) begin
        n_checks++; n_err++;
        $display("FAIL single_release_busy got %b exp 1", busy);
      end else if (c == 5) n_checks++;
      if (c == 6) begin
        n_checks++;
        if (m_valid !== 1'b0) begin
          n_err++; $display("FAIL single_drain got m_valid=%b exp 0", m_valid);
        end
      end
      if (c == 7) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_err++; $display("FAIL single_idle got busy=%b exp 0", busy);
        end
      end
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    @(negedge clk);
    #2;
    send_pkt(0, 2, 32'h0000_0100, -1, 0);
    send_pkt(3, 2, 32'h3000_0300, -1, 0);
    build_exp(0);
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (busy && owner == 3'd0) begin
        n_checks++;
        if (s_ready[3] !== 1'b0) begin
          n_err++; $display("FAIL cont_starve got s_ready[3]=%b exp 0", s_ready[3]);
        end
      end
      if (c > 2 && all_sent() && !busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL cont_timeout got busy=%b exp idle", busy);
    end
    n_checks++;
    if (out_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL cont_count got %0d exp %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL cont_beat%0d got %h exp %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_fairness();
    int own_log [$];
    bit prev_busy;
    bit ok;
    do_reset();
    @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      send_pkt(1, $urandom_range(1, 3), (32'd1 << 28) | (DW'(k) << 8), -1, 0);
      send_pkt(4, $urandom_range(1, 3), (32'd4 << 28) | (DW'(k) << 8), -1, 0);
    end
    build_exp(0);
    prev_busy = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (busy && !prev_busy) own_log.push_back(int'(owner));
      prev_busy = busy;
      if (c > 2 && all_sent() && !busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL fair_timeout got busy=%b exp idle", busy);
    end
    n_checks++;
    if (own_log.size() != ord_q.size()) begin
      n_err++; $display("FAIL fair_npkts got %0d exp %0d", own_log.size(), ord_q.size());
    end
    for (int i = 0; i < ord_q.size() && i < own_log.size(); i++) begin
      n_checks++;
      if (own_log[i] != ord_q[i]) begin
        n_err++; $display("FAIL fair_owner%0d got %0d exp %0d", i, own_log[i], ord_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL fair_beat%0d got %h exp %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    bit prev_stall;
    logic [DW-1:0] pd;
    logic pl;
    bit ok;
    do_reset();
    @(negedge clk);
    #2;
    mr_mode = 2;
    send_pkt(2, 4, 32'h2000_00B0, -1, 0);
    build_exp(0);
    prev_stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          n_err++;
          $display("FAIL bp_hold got %b/%h/%b exp 1/%h/%b", m_valid, m_data, m_last, pd, pl);
        end
      end
`ifndef RR_STREAM_MUX_SKID_EN
      if (m_valid && !m_ready) begin
        n_checks++;
        if (s_ready !== '0) begin
          n_err++; $display("FAIL bp_s_ready got %b exp 0", s_ready);
        end
      end
`endif
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (all_sent() && !busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL bp_timeout got busy=%b exp idle", busy);
    end
    n_checks++;
    if (out_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL bp_count got %0d exp %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_beat%0d got %h exp %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_valid_gap();
    bit ok;
    int gaps;
    do_reset();
    @(negedge clk);
    #2;
    send_pkt(0, 4, 32'h0000_0C00, 2, 5);
    send_pkt(5, 1, 32'h5000_0500, 0, 4);
    build_exp(0);
    ok = 1'b0;
    gaps = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy && owner == 3'd0 && !s_valid[0] && src_q[0].size() > 0) begin
        gaps++;
        n_checks++;
        if (arb_request !== 6'b000001 || arb_grant !== 6'b000001 || s_ready[5] !== 1'b0) begin
          n_err++;
          $display("FAIL gap_lock got req=%b grant=%b s_ready=%b exp 000001/000001/0xxxxx",
                   arb_request, arb_grant, s_ready);
        end
      end
      if (c > 2 && all_sent() && !busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok || gaps < 5) begin
      n_err++; $display("FAIL gap_run got done=%b gaps=%0d exp 1/>=5", ok, gaps);
    end
    n_checks++;
    if (out_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL gap_count got %0d exp %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_checks++;
      if (out_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL gap_beat%0d got %h exp %h", i, out_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    @(negedge clk);
    #2;
    send_pkt(1, 4, 32'h1000_0D00, -1, 0);
    seen = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (m_valid && m_data == 32'h1000_0D01) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_err++; $display("FAIL rmid_beat2 got m_data=%h exp 10000d01", m_data);
    end else begin
      #2;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (m_valid !== 1'b0 || s_ready !== '0 || busy !== 1'b0 || owner !== '0) begin
        n_err++;
        $display("FAIL rmid_flush got mv=%b sr=%b busy=%b owner=%0d exp 0/0/0/0",
                 m_valid, s_ready, busy, owner);
      end
      n_checks++;
      if (arb_request !== '0) begin
        n_err++; $display("FAIL rmid_arb_request got %b exp 0", arb_request);
      end
    end
    do_reset();
  endtask

  task automatic test_random();
    int pushed;
    int p;
    int len;
    int cur;
    bit ok;
    bit prev_stall;
    logic [DW-1:0] pd;
    logic pl;
    do_reset();
    gap_pct = 30;
    mr_mode = 1;
    pushed = 0;
    ok = 1'b0;
    prev_stall = 1'b0;
    pd = '0;
    pl = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
          n_err++;
          $display("FAIL rand_hold got %b/%h/%b exp 1/%h/%b", m_valid, m_data, m_last, pd, pl);
        end
      end
      n_checks++;
      if (!$onehot0(s_ready)) begin
        n_err++; $display("FAIL rand_s_ready got %b exp onehot0", s_ready);
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      if (pushed < 40 && $urandom_range(3) == 0) begin
        p = $urandom_range(N - 1);
        len = $urandom_range(1, 4);
        send_pkt(p, len, (DW'(p) << 28) | (DW'(pushed) << 16) | DW'($urandom_range(255) << 4),
                 $urandom_range(len - 1), $urandom_range(3));
        pushed++;
      end
      if (pushed == 40 && all_sent() && !busy && !m_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_err++; $display("FAIL rand_timeout got pushed=%0d busy=%b exp done", pushed, busy);
    end
    cur = -1;
    foreach (out_q[i]) begin
      n_checks++;
      if (cur < 0) begin
        for (int q = 0; q < N; q++) begin
          if (cur < 0 && mdl_q[q].size() > 0 && mdl_q[q][0] == out_q[i]) cur = q;
        end
      end
      if (cur < 0 || mdl_q[cur].size() == 0 || out_q[i] !== mdl_q[cur][0]) begin
        n_err++;
        $display("FAIL rand_beat%0d got %h exp next beat of port %0d", i, out_q[i], cur);
        cur = -1;
      end else begin
        mdl_q[cur].delete(0);
        if (out_q[i].last) cur = -1;
      end
    end
    for (int q = 0; q < N; q++) begin
      n_checks++;
      if (mdl_q[q].size() != 0) begin
        n_err++; $display("FAIL rand_left port%0d got %0d beats left exp 0", q, mdl_q[q].size());
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    s_valid = '0;
    s_last  = '0;
    s_data  = '0;
    m_ready = 1'b1;
    mr_mode = 0;
    gap_pct = 0;
    bp      = 0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_back_pressure();
    test_valid_gap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
